prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader sitting directly upstream of the pipeline processor. It accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory from address 0. It then holds the processor in reset for a settle interval and releases it. A reload request re-enters load mode and re-asserts processor reset.

## Interface
- ADDR_W, 21: instruction-memory address width; capacity = 2^ADDR_W words.
- SETTLE_CYCLES, 4: cycles cpu_reset stays asserted after the last word is written (≥1).
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- load_valid  in  1  upstream word present on load_data.
- load_data  in  16  instruction word.
- load_last  in  1  qualifies load_data as the final word of the image.
- load_ready  out  1  loader can accept a word this cycle.
- reload  in  1  single-cycle request to load a new image (honoured only in RUN or ERR).
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  instruction-memory write address.
- imem_wdata  out  16  instruction-memory write data.
- cpu_reset  out  1  active-low processor reset; drives processor `reset`.
- done  out  1  high while the processor runs a loaded image.
- error  out  1  image overflowed memory; sticky until reset or reload.
- word_count  out  ADDR_W+1  number of words written by the last or current load.

## Operation
- States: LOAD, SETTLE, RUN, ERR. Reset enters LOAD.
- Transfer occurs on a cycle with load_valid && load_ready.
- LOAD:
  - load_ready=1, cpu_reset=0.
  - On each transfer: imem_we=1, imem_addr=wr_ptr, imem_wdata=load_data (registered, visible next cycle); then wr_ptr+=1 and word_count+=1.
  - If the transfer has load_last=1: go to SETTLE with settle counter = SETTLE_CYCLES-1.
  - If the transfer has wr_ptr = 2^ADDR_W-1 and load_last=0: the word is still written; go to ERR. wr_ptr must not wrap to 0.
- SETTLE:
  - load_ready=0, cpu_reset=0.
  - Counter decrements each cycle. At 0, go to RUN.
- RUN:
  - cpu_reset=1, done=1, load_ready=0. Inputs on load_* are ignored.
  - reload=1: go to LOAD, wr_ptr=0, word_count=0, cpu_reset=0 from the next cycle.
- ERR:
  - error=1, cpu_reset=0, load_ready=0.
  - reload=1: same as in RUN; error clears on entry to LOAD.
- reload in LOAD or SETTLE is ignored.
- load_last with load_valid=0 has no effect.
- word_count saturates at 2^ADDR_W and is held (not cleared) in SETTLE, RUN and ERR.

## Timing
- Reset values (cycle after reset sampled low): state=LOAD, load_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=0, done=0, error=0, word_count=0.
- Reset asserted mid-load or mid-run aborts immediately:
  - cpu_reset=0 and the state returns to LOAD.
  - Words already written remain in memory.
- Write latency: imem_we/addr/wdata are registered, one cycle after the transfer edge. Back-to-back transfers produce one write per cycle, with no bubbles.
- load_ready is a function of state only (registered). There is no combinational path from load_valid to load_ready.
- Release timing:
  - The last transfer occurs at edge N. The state is SETTLE from N+1 to N+SETTLE_CYCLES.
  - cpu_reset rises and done rises after edge N+SETTLE_CYCLES, i.e. state=RUN.
  - Because the final write lands at N+1, the final word is in memory before the processor leaves reset, for any SETTLE_CYCLES≥1.
- reload to cpu_reset low: 1 cycle. load_ready=1 in the same cycle that cpu_reset falls.

## Test plan
- Basic load:
  - Stimulus: reset low for 2 cycles; then stream 0x1111, 0x2222, 0x3333 (last on the third) back-to-back.
  - Expect: writes at addr 0,1,2 on consecutive cycles; word_count=3; cpu_reset low exactly through SETTLE_CYCLES=4 cycles after the last transfer, then 1; done=1.
- Gapped/backpressure-free stream:
  - Stimulus: load_valid toggles 1,0,1,0 with words 0xA5A5, 0x5A5A (last).
  - Expect: exactly 2 writes at addr 0,1; no write on idle cycles.
- Overflow:
  - Stimulus: ADDR_W=3; 9 words, none marked last.
  - Expect: 8 writes (addr 0–7); error=1 after the 8th; 9th word not accepted (load_ready=0); cpu_reset stays 0; word_count=8.
- Reload:
  - Stimulus: in RUN, pulse reload; stream 0xBEEF (last).
  - Expect: cpu_reset=0 next cycle; done=0; write 0xBEEF at addr 0; word_count=1; RUN again after the settle interval.
- Reset mid-operation:
  - Stimulus: assert reset after 2 of 4 words.
  - Expect: all outputs at reset values next cycle; a fresh stream restarts at addr 0.
- Ignored inputs:
  - Stimulus: reload during LOAD and SETTLE; load_valid with 0xFFFF during RUN.
  - Expect: no state change, no imem_we.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the pipeline processor.
//
// Accepts a stream of 16-bit instruction words over a valid/ready handshake
// and writes them into instruction memory starting at address 0. Once the
// word marked last has been accepted, the processor is held in reset for
// SETTLE_CYCLES cycles and then released. A reload request (honoured in RUN
// or ERR) re-enters load mode and puts the processor back into reset.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   load_valid   upstream word present on load_data
//   load_data    instruction word
//   load_last    marks load_data as the final word of the image
//   load_ready   loader accepts a word this cycle (depends on state only)
//   reload       single-cycle request to load a new image
//   imem_we      instruction-memory write strobe (registered)
//   imem_addr    instruction-memory write address (registered)
//   imem_wdata   instruction-memory write data (registered)
//   cpu_reset    active-low processor reset
//   done         processor is running a loaded image
//   error        image overflowed the memory
//   word_count   number of words written by the last or current load
module prog_loader #(
    parameter int ADDR_W        = 21,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [15:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    // The settle counter only ever holds values 0..SETTLE_CYCLES-1.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] PTR_MAX     = '1;
    localparam logic [ADDR_W:0]   COUNT_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0]  SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W:0]     word_count_reg;
    logic [CNT_W-1:0]    settle_cnt_reg;
    logic                imem_we_reg;
    logic [ADDR_W-1:0]   imem_addr_reg;
    logic [15:0]         imem_wdata_reg;
    logic                xfer;
    logic                restart;

    assign xfer    = load_valid && load_ready;
    assign restart = reload && (state_reg == ST_RUN || state_reg == ST_ERR);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD: begin
                if (xfer) begin
                    // A last word written into the top address still counts
                    // as a complete image; only a non-last one overflows.
                    if (load_last) begin
                        state_next = ST_SETTLE;
                    end else if (wr_ptr_reg == PTR_MAX) begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_reg == '0) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN, ST_ERR: begin
                if (reload) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // Outputs decoded from the registered state only, so load_ready has no
    // combinational dependence on load_valid.
    always_comb begin
        load_ready = (state_reg == ST_LOAD);
        cpu_reset  = (state_reg == ST_RUN);
        done       = (state_reg == ST_RUN);
        error      = (state_reg == ST_ERR);
    end

    // Write pointer, counters and registered memory write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            word_count_reg <= '0;
            settle_cnt_reg <= '0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
        end else begin
            imem_we_reg <= xfer;
            if (xfer) begin
                imem_addr_reg  <= wr_ptr_reg;
                imem_wdata_reg <= load_data;
                // Pointer parks at the top address instead of wrapping.
                if (wr_ptr_reg != PTR_MAX) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (word_count_reg != COUNT_MAX) begin
                    word_count_reg <= word_count_reg + 1'b1;
                end
            end

            if (xfer && load_last) begin
                settle_cnt_reg <= SETTLE_INIT;
            end else if (state_reg == ST_SETTLE && settle_cnt_reg != '0) begin
                settle_cnt_reg <= settle_cnt_reg - 1'b1;
            end

            if (restart) begin
                wr_ptr_reg     <= '0;
                word_count_reg <= '0;
            end
        end
    end

    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader. A default-sized instance (ADDR_W=21)
// covers load, release timing, reload, ignored inputs and mid-load reset; a
// small instance (ADDR_W=3) covers memory overflow.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;

    // Default-sized instance.
    logic        load_valid, load_last, reload;
    logic [15:0] load_data;
    logic        load_ready, imem_we, cpu_reset, done, error;
    logic [20:0] imem_addr;
    logic [15:0] imem_wdata;
    logic [21:0] word_count;

    // Small instance for overflow.
    logic        s_load_valid, s_load_last, s_reload;
    logic [15:0] s_load_data;
    logic        s_load_ready, s_imem_we, s_cpu_reset, s_done, s_error;
    logic [2:0]  s_imem_addr;
    logic [15:0] s_imem_wdata;
    logic [3:0]  s_word_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(21), .SETTLE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    prog_loader #(.ADDR_W(3), .SETTLE_CYCLES(4)) dut_small (
        .clk        (clk),
        .reset      (reset),
        .load_valid (s_load_valid),
        .load_data  (s_load_data),
        .load_last  (s_load_last),
        .load_ready (s_load_ready),
        .reload     (s_reload),
        .imem_we    (s_imem_we),
        .imem_addr  (s_imem_addr),
        .imem_wdata (s_imem_wdata),
        .cpu_reset  (s_cpu_reset),
        .done       (s_done),
        .error      (s_error),
        .word_count (s_word_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One clock edge; outputs are observed 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transfer one word on the default instance and check the resulting write.
    task automatic send_word(input string tag, input logic [15:0] data, input logic last,
                             input logic [31:0] exp_addr);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        check_val({tag, "_we"},    32'(imem_we),    32'd1);
        check_val({tag, "_addr"},  32'(imem_addr),  exp_addr);
        check_val({tag, "_wdata"}, 32'(imem_wdata), 32'(data));
    endtask

    // After a last-word transfer: cpu_reset held low for the full settle
    // interval (SETTLE already visible after the transfer edge), then RUN.
    task automatic expect_release(input string tag);
        check_val({tag, "_settle0_cpurst"}, 32'(cpu_reset), 32'd0);
        check_val({tag, "_settle0_ready"},  32'(load_ready), 32'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            check_val({tag, "_settle_cpurst"}, 32'(cpu_reset), 32'd0);
            check_val({tag, "_settle_we"},     32'(imem_we),   32'd0);
        end
        step();
        check_val({tag, "_run_cpurst"}, 32'(cpu_reset), 32'd1);
        check_val({tag, "_run_done"},   32'(done),      32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_ready"},  32'(load_ready), 32'd1);
        check_val({tag, "_we"},     32'(imem_we),    32'd0);
        check_val({tag, "_addr"},   32'(imem_addr),  32'd0);
        check_val({tag, "_wdata"},  32'(imem_wdata), 32'd0);
        check_val({tag, "_cpurst"}, 32'(cpu_reset),  32'd0);
        check_val({tag, "_done"},   32'(done),       32'd0);
        check_val({tag, "_error"},  32'(error),      32'd0);
        check_val({tag, "_wcount"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        load_valid = 1'b0; load_last = 1'b0; load_data = '0; reload = 1'b0;
        s_load_valid = 1'b0; s_load_last = 1'b0; s_load_data = '0; s_reload = 1'b0;

        // Reset values
        step();
        step();
        check_reset_values("rst");
        reset = 1'b1;

        // Basic back-to-back load
        send_word("basic0", 16'h1111, 1'b0, 0);
        send_word("basic1", 16'h2222, 1'b0, 1);
        send_word("basic2", 16'h3333, 1'b1, 2);
        check_val("basic_wcount", 32'(word_count), 32'd3);
        expect_release("basic");

        // Reload from RUN
        reload = 1'b1;
        step();
        reload = 1'b0;
        check_val("reload_cpurst", 32'(cpu_reset),  32'd0);
        check_val("reload_done",   32'(done),       32'd0);
        check_val("reload_ready",  32'(load_ready), 32'd1);
        check_val("reload_wcount", 32'(word_count), 32'd0);
        send_word("reload0", 16'hBEEF, 1'b1, 0);
        check_val("reload_wcount1", 32'(word_count), 32'd1);
        expect_release("reload");

        // load_* ignored in RUN
        load_valid = 1'b1; load_data = 16'hFFFF; load_last = 1'b1;
        step();
        step();
        load_valid = 1'b0; load_last = 1'b0;
        check_val("run_ign_we",     32'(imem_we),    32'd0);
        check_val("run_ign_done",   32'(done),       32'd1);
        check_val("run_ign_wcount", 32'(word_count), 32'd1);

        // Gapped stream; reload and lone load_last on the idle cycle ignored
        reload = 1'b1;
        step();
        reload = 1'b0;
        send_word("gap0", 16'hA5A5, 1'b0, 0);
        reload = 1'b1; load_last = 1'b1;
        step();
        reload = 1'b0; load_last = 1'b0;
        check_val("gap_idle_we",    32'(imem_we),    32'd0);
        check_val("gap_idle_ready", 32'(load_ready), 32'd1);
        send_word("gap1", 16'h5A5A, 1'b1, 1);
        check_val("gap_wcount", 32'(word_count), 32'd2);
        // reload during the first SETTLE cycle must not shorten or abort it
        reload = 1'b1;
        expect_release("gap");
        reload = 1'b0;
        check_val("gap_ign_reload_wcount", 32'(word_count), 32'd2);

        // Reset mid-load
        reload = 1'b1;
        step();
        reload = 1'b0;
        send_word("mid0", 16'h0101, 1'b0, 0);
        send_word("mid1", 16'h0202, 1'b0, 1);
        reset = 1'b0;
        step();
        check_reset_values("midrst");
        reset = 1'b1;
        send_word("restart0", 16'h7777, 1'b1, 0);
        check_val("restart_wcount", 32'(word_count), 32'd1);

        // Overflow on ADDR_W=3 instance: 9 words, none marked last
        s_load_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_load_data = 16'(16'h0C00 + i);
            step();
            check_val("ovf_we",    32'(s_imem_we),    32'd1);
            check_val("ovf_addr",  32'(s_imem_addr),  32'(i));
            check_val("ovf_wdata", 32'(s_imem_wdata), 32'(16'h0C00 + i));
        end
        check_val("ovf_error",  32'(s_error),      32'd1);
        check_val("ovf_ready",  32'(s_load_ready), 32'd0);
        check_val("ovf_wcount", 32'(s_word_count), 32'd8);
        s_load_data = 16'h0C08;
        step();
        s_load_valid = 1'b0;
        check_val("ovf9_we",     32'(s_imem_we),    32'd0);
        check_val("ovf9_error",  32'(s_error),      32'd1);
        check_val("ovf9_cpurst", 32'(s_cpu_reset),  32'd0);
        check_val("ovf9_done",   32'(s_done),       32'd0);
        check_val("ovf9_wcount", 32'(s_word_count), 32'd8);
        s_reload = 1'b1;
        step();
        s_reload = 1'b0;
        check_val("ovf_reload_error",  32'(s_error),      32'd0);
        check_val("ovf_reload_ready",  32'(s_load_ready), 32'd1);
        check_val("ovf_reload_wcount", 32'(s_word_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
